uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised oversampling UART receiver with majority-vote bit decisions, stop-bit checking, optional parity and a receive FIFO. It sits between the serial input pin and the processor bus, driven by the shared baud-rate generator's oversample enable. It replaces the single-byte, 8-bit-only receiver with buffered, width-configurable reception and error reporting.

## Interface
- DATA_BITS, 8, data bits per frame, 5..9, LSB first
- OVERSAMPLE, 16, r_enable ticks per bit, even, 8..32
- FIFO_DEPTH, 4, receive FIFO entries, power of 2, ≥2
- PARITY_ODD, 0, 1 = odd parity, 0 = even; used only with UART_RX_PARITY_EN
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- r_enable  in  1  oversample tick, one clk wide
- rxd  in  1  serial input, asynchronous, idle high
- rec_enable  in  1  pop strobe, one clk wide
- err_clr  in  1  clears all sticky error flags
- data  out  DATA_BITS  FIFO head, first-word fall-through
- rda  out  1  FIFO not empty
- frame_err  out  1  sticky: a stop bit was sampled as 0
- parity_err  out  1  sticky: parity mismatch; constant 0 without the macro
- overrun  out  1  sticky: a good frame arrived while the FIFO was full

## Operation
- rxd passes through a 2-flop synchroniser, and all sampling uses the synchronised value. The flops are not reset.
- Each bit window is OVERSAMPLE ticks. Zeros are counted per window, and the bit is 0 iff zeros > OVERSAMPLE/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: the first tick sampling 0 enters START. That sample counts as the first sample of the window.
  - START: at the end of the window, a 0 bit goes to DATA. A 1 bit is a false start: no flags change, and the FSM returns to IDLE.
  - DATA: shifts DATA_BITS bits LSB first, then goes to PARITY if the macro is defined, otherwise to STOP.
  - PARITY: compares the received bit with the computed parity, then goes to STOP.
  - STOP: at the end of the window, the FSM always returns to IDLE.
- End of STOP, stop bit = 0: the frame is discarded and frame_err is set.
- End of STOP, parity mismatch: the frame is discarded and parity_err is set.
- End of STOP, good frame with FIFO full and no pop that cycle: the frame is discarded and overrun is set.
- End of STOP, good frame otherwise: the frame is pushed.
- FIFO:
  - Circular buffer with ptr width log2(FIFO_DEPTH) and a separate count of width log2(FIFO_DEPTH)+1.
  - Pointers wrap modulo FIFO_DEPTH.
  - rec_enable with rda=1 pops. rec_enable with rda=0 is ignored, and count does not underflow.
  - Simultaneous push and pop: both occur and count is unchanged. This includes the full case, so no overrun.
- err_clr clears the flags in the same edge. If a flag's setting event coincides with err_clr, the flag is set.
- rst at any time, including mid-frame, returns the FSM to IDLE and empties the FIFO. The FIFO is not drained.

## Timing
- Reset values: data=0, rda=0, frame_err=0, parity_err=0, overrun=0. FIFO storage is not cleared, but data is forced to 0 while empty.
- Synchroniser latency is 2 clk.
- A push occurs on the clk edge following the OVERSAMPLE-th stop-bit tick. rda and data are valid from the next cycle.
- rda is derived combinationally from the registered count (count != 0).
- A pop updates data and rda in the cycle after rec_enable.
- A pop followed by rec_enable in the very next cycle pops the next entry. Back-to-back pops are allowed.
- Error flags assert in the cycle after the end-of-STOP edge.
- Minimum frame length is (2 + DATA_BITS [+1 parity]) × OVERSAMPLE ticks. A new start bit is accepted on the first 0 tick after STOP ends.

## Configuration
- UART_RX_PARITY_EN defined:
  - A parity bit follows the data bits, and the PARITY state is used.
  - Parity is even (PARITY_ODD=0) or odd (PARITY_ODD=1).
  - Mismatches are discarded and flagged on parity_err.
- UART_RX_PARITY_EN undefined:
  - There is no PARITY state and no parity bit.
  - parity_err is tied to 0, and PARITY_ODD is ignored.

## Test plan
- Defaults, no macro: send 0xA5 with OVERSAMPLE=16 ticks/bit. rda rises once, data=0xA5, rec_enable → rda=0.
- False start: rxd low for 5 ticks, then high. No push, FSM in IDLE, no flags. Then a valid 0x3C frame is received correctly.
- Stop bit 0 on frame 0x55: frame_err=1, rda stays 0. err_clr → frame_err=0.
- FIFO_DEPTH=4: send 0x01..0x05 with no pops.
  - Expect overrun=1 and count=4.
  - Pops return 0x01..0x04, then rda=0.
  - A push coinciding with a pop while full → no overrun.
- DATA_BITS=7, macro defined, PARITY_ODD=1: 0x41 with parity 1 is accepted. 0x41 with parity 0 → parity_err=1 and no push.
- Assert rst mid-DATA with 2 entries queued. Next cycle rda=0 and all flags=0, and the following frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bits, stop/parity checking and a FWFT receive FIFO.
// Optional parity bit is enabled by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 r_enable,
    input  logic                 rxd,
    input  logic                 rec_enable,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] data,
    output logic                 rda,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int CW   = $clog2(OVERSAMPLE);
    localparam int ZW   = $clog2(OVERSAMPLE + 1);
    localparam int IW   = $clog2(DATA_BITS);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CNTW = AW + 1;
    localparam logic [CW-1:0]   TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [ZW-1:0]   HALF      = ZW'(OVERSAMPLE / 2);
    localparam logic [IW-1:0]   BIT_LAST  = IW'(DATA_BITS - 1);
    localparam logic [CNTW-1:0] FULL      = CNTW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state_reg, state_next;
    logic                  rxd_meta_reg, rxd_sync_reg;
    logic [CW-1:0]         tick_cnt_reg;
    logic [ZW-1:0]         zero_cnt_reg;
    logic [IW-1:0]         bit_idx_reg;
    logic [DATA_BITS-1:0]  shift_reg;
    logic [DATA_BITS-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [CNTW-1:0]       count_reg, count_next;
    logic [DATA_BITS-1:0]  data_reg;
    logic                  frame_err_reg, overrun_reg;
    logic                  rx_zero, bit_val, win_end, frame_done, par_bad, good, pop, push;
    logic                  frame_err_set, overrun_set;
    logic [ZW-1:0]         zeros_total;

    // Synchroniser is deliberately unreset; it only ever carries the pin value.
    always_ff @(posedge clk) begin
        rxd_meta_reg <= rxd;
        rxd_sync_reg <= rxd_meta_reg;
    end

    assign rx_zero     = ~rxd_sync_reg;
    assign zeros_total = zero_cnt_reg + ZW'(rx_zero);
    assign bit_val     = ~(zeros_total > HALF);
    assign win_end     = r_enable && (state_reg != IDLE) && (tick_cnt_reg == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            zero_cnt_reg <= '0;
            bit_idx_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE) begin
                bit_idx_reg <= '0;
                // The detecting tick is the first sample of the start-bit window.
                if (r_enable && rx_zero) begin
                    tick_cnt_reg <= CW'(1);
                    zero_cnt_reg <= ZW'(1);
                end else begin
                    tick_cnt_reg <= '0;
                    zero_cnt_reg <= '0;
                end
            end else if (r_enable) begin
                if (tick_cnt_reg == TICK_LAST) begin
                    tick_cnt_reg <= '0;
                    zero_cnt_reg <= '0;
                end else begin
                    tick_cnt_reg <= tick_cnt_reg + CW'(1);
                    zero_cnt_reg <= zeros_total;
                end
            end
            if (state_reg == DATA && win_end)
                bit_idx_reg <= bit_idx_reg + IW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (state_reg == DATA && win_end)
            shift_reg <= {bit_val, shift_reg[DATA_BITS-1:1]};
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (r_enable && rx_zero) state_next = START;
            START:  if (win_end) state_next = bit_val ? IDLE : DATA;
            DATA:   if (win_end && bit_idx_reg == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
`ifdef UART_RX_PARITY_EN
            PARITY: if (win_end) state_next = STOP;
`endif
            STOP:   if (win_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit_reg, parity_err_reg, parity_err_set;

    always_ff @(posedge clk) begin
        if (state_reg == PARITY && win_end)
            par_bit_reg <= bit_val;
    end

    // Data bits plus parity bit must have odd/even population as configured.
    assign par_bad = ((^shift_reg) ^ par_bit_reg) != (PARITY_ODD != 0);

    always_ff @(posedge clk) begin
        if (rst)
            parity_err_reg <= 1'b0;
        else
            parity_err_reg <= parity_err_set | (parity_err_reg & ~err_clr);
    end
    assign parity_err_set = frame_done && bit_val && par_bad;
    assign parity_err     = parity_err_reg;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
    assign par_bad    = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Frame-end decisions: stop error wins over parity error; a pop frees room for the push.
    always_comb begin
        frame_done    = (state_reg == STOP) && win_end;
        good          = frame_done && bit_val && !par_bad;
        pop           = rec_enable && rda;
        push          = good && ((count_reg != FULL) || pop);
        overrun_set   = good && (count_reg == FULL) && !pop;
        frame_err_set = frame_done && !bit_val;
    end

    assign rd_ptr_next = rd_ptr_reg + AW'(pop);
    assign count_next  = count_reg + CNTW'(push) - CNTW'(pop);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= shift_reg;
    end

    // Registered head read; bypass the write when the new word lands at the next head slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            data_reg   <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (count_next == '0)
                data_reg <= '0;
            else if (push && wr_ptr_reg == rd_ptr_next)
                data_reg <= shift_reg;
            else
                data_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            frame_err_reg <= frame_err_set | (frame_err_reg & ~err_clr);
            overrun_reg   <= overrun_set | (overrun_reg & ~err_clr);
        end
    end

    assign data      = data_reg;
    assign rda       = (count_reg != '0);
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames driven bit by bit on rxd with a bench-paced oversample tick.
// Parity cases run on a second 7-bit odd-parity instance when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       r_enable = 1'b0;
    logic       rxd = 1'b1;
    logic       rec_enable = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data;
    logic       rda, frame_err, parity_err, overrun;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DATA_BITS(8), .OVERSAMPLE(OS), .FIFO_DEPTH(4), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rst(rst), .r_enable(r_enable), .rxd(rxd), .rec_enable(rec_enable),
        .err_clr(err_clr), .data(data), .rda(rda), .frame_err(frame_err),
        .parity_err(parity_err), .overrun(overrun)
    );

`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    logic [6:0] data_p;
    logic       rda_p, frame_err_p, parity_err_p, overrun_p;

    uart_rx_fifo #(.DATA_BITS(7), .OVERSAMPLE(OS), .FIFO_DEPTH(4), .PARITY_ODD(1)) u_dut_p (
        .clk(clk), .rst(rst), .r_enable(r_enable), .rxd(rxd), .rec_enable(rec_enable),
        .err_clr(err_clr), .data(data_p), .rda(rda_p), .frame_err(frame_err_p),
        .parity_err(parity_err_p), .overrun(overrun_p)
    );
`else
    localparam bit PAR_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // One oversample tick: two idle clocks let the synchroniser settle after an rxd change.
    task automatic tick(input bit p);
        @(negedge clk);
        @(negedge clk);
        r_enable   = 1'b1;
        rec_enable = p;
        @(negedge clk);
        r_enable   = 1'b0;
        rec_enable = 1'b0;
    endtask

    task automatic send_bit(input logic v, input bit pop_last);
        rxd = v;
        for (int i = 0; i < OS; i++) tick(pop_last && (i == OS - 1));
    endtask

    task automatic send_frame(input logic [8:0] d, input int nb, input bit pe,
                              input logic pv, input logic sv, input bit pop_last);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < nb; i++) send_bit(d[i], 1'b0);
        if (pe) send_bit(pv, 1'b0);
        send_bit(sv, pop_last);
        $display("frame %0h stop=%0b sent", d, sv);
    endtask

    task automatic tx(input logic [7:0] d, input logic sv, input bit pop_last);
        send_frame({1'b0, d}, 8, PAR_EN, ^d, sv, pop_last);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, data, exp);
        check({tag, "_rda"}, rda, 1);
        rec_enable = 1'b1;
        @(negedge clk);
        rec_enable = 1'b0;
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_data", data, 0);
        check("rst_rda", rda, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);

        // Basic frame
        tx(8'hA5, 1'b1, 1'b0);
        check("a5_rda", rda, 1);
        check("a5_data", data, 8'hA5);
        rec_enable = 1'b1;
        @(negedge clk);
        rec_enable = 1'b0;
        check("a5_pop_rda", rda, 0);
        check("a5_pop_data", data, 0);

        // False start then a valid frame
        rxd = 1'b0;
        repeat (5) tick(1'b0);
        send_bit(1'b1, 1'b0);
        check("false_rda", rda, 0);
        check("false_frame_err", frame_err, 0);
        check("false_overrun", overrun, 0);
        tx(8'h3C, 1'b1, 1'b0);
        pop_check("3c_data", 8'h3C);
        check("3c_empty", rda, 0);

        // Stop bit sampled as 0
        tx(8'h55, 1'b0, 1'b0);
        check("stop0_frame_err", frame_err, 1);
        check("stop0_rda", rda, 0);
        send_bit(1'b1, 1'b0);
        clear_errors();
        check("clr_frame_err", frame_err, 0);

        // Fill to overrun, then back-to-back pops
        for (int i = 1; i <= 4; i++) tx(8'(i), 1'b1, 1'b0);
        check("full_overrun", overrun, 0);
        tx(8'h05, 1'b1, 1'b0);
        check("ovr_overrun", overrun, 1);
        for (int i = 1; i <= 4; i++) pop_check("ovr_pop", 8'(i));
        check("ovr_empty", rda, 0);
        check("ovr_empty_data", data, 0);
        clear_errors();
        check("clr_overrun", overrun, 0);

        // Push coinciding with pop while full
        for (int i = 0; i < 4; i++) tx(8'h10 + 8'(i), 1'b1, 1'b0);
        tx(8'h14, 1'b1, 1'b1);
        check("pp_overrun", overrun, 0);
        for (int i = 1; i <= 4; i++) pop_check("pp_pop", 8'h10 + 8'(i));
        check("pp_empty", rda, 0);

        // Reset mid-DATA with two entries queued and a sticky flag set
        tx(8'h55, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        tx(8'h21, 1'b1, 1'b0);
        tx(8'h22, 1'b1, 1'b0);
        check("pre_rst_rda", rda, 1);
        check("pre_rst_frame_err", frame_err, 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_rda", rda, 0);
        check("mid_rst_data", data, 0);
        check("mid_rst_frame_err", frame_err, 0);
        check("mid_rst_overrun", overrun, 0);
        send_bit(1'b1, 1'b0);
        tx(8'h7E, 1'b1, 1'b0);
        pop_check("7e_data", 8'h7E);
        check("7e_empty", rda, 0);

`ifdef UART_RX_PARITY_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_bit(1'b1, 1'b0);
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        check("par_ok_rda", rda_p, 1);
        check("par_ok_data", data_p, 7'h41);
        check("par_ok_err", parity_err_p, 0);
        rec_enable = 1'b1;
        @(negedge clk);
        rec_enable = 1'b0;
        check("par_ok_empty", rda_p, 0);
        send_frame(9'h041, 7, 1'b1, 1'b0, 1'b1, 1'b0);
        check("par_bad_err", parity_err_p, 1);
        check("par_bad_rda", rda_p, 0);
        check("par_bad_frame_err", frame_err_p, 0);
        check("par_bad_overrun", overrun_p, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
